// File: rtl/main_memory_wb_ctrl.sv
// Block-granular main memory behind the write-back cache: 64 x 128-bit blocks with a
// programmable per-phase latency and valid/ready request/response handshakes.
module main_memory_wb_ctrl #(
  parameter int unsigned LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [9:0]   req_addr,
  input  logic [9:0]   req_wb_addr,
  input  logic [127:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_rdata,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {StIdle, StWrWait, StRdWait, StResp} state_e;
  typedef logic [63:0][127:0] mem_t;

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  // Power-up image: every word holds its own byte address.
  function automatic mem_t init_mem();
    mem_t m;
    for (int b = 0; b < 64; b++) begin
      for (int w = 0; w < 4; w++) begin
        m[b[5:0]][127 - 32 * w -: 32] = 32'(b * 16 + w * 4);
      end
    end
    return m;
  endfunction

  mem_t mem_q = init_mem();

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [1:0]   op_q, op_d;
  logic [5:0]   addr_q, addr_d;
  logic [5:0]   wb_addr_q, wb_addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [127:0] rdata_q, rdata_d;
  logic [15:0]  rd_count_q, rd_count_d;
  logic [15:0]  wr_count_q, wr_count_d;
  logic         mem_we;
  logic [5:0]   mem_widx;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[3:0], req_wb_addr[3:0]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wb_addr_d  = wb_addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
    mem_widx   = (op_q == 2'b10) ? wb_addr_q : addr_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr[9:4];
          wb_addr_d = req_wb_addr[9:4];
          wdata_d   = req_wdata;
          cnt_d     = CntLoad;
          state_d   = (req_op == 2'b01 || req_op == 2'b10) ? StWrWait : StRdWait;
        end
      end
      StWrWait: begin
        if (cnt_q == 4'd0) begin
          // A reset on the commit edge must suppress the write.
          mem_we     = ~reset;
          wr_count_d = wr_count_q + 16'd1;
          if (op_q == 2'b10) begin
            cnt_d   = CntLoad;
            state_d = StRdWait;
          end else begin
            rdata_d = '0;
            state_d = StResp;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdWait: begin
        if (cnt_q == 4'd0) begin
          rdata_d    = mem_q[addr_q];
          rd_count_d = rd_count_q + 16'd1;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wb_addr_q  <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wb_addr_q  <= wb_addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_widx] <= wdata_q;
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_main_memory_wb_ctrl.sv
// Directed bench for main_memory_wb_ctrl: latency, data, hazard, stall and abort cases.
module tb_main_memory_wb_ctrl;

  localparam int Lat = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [9:0]   req_addr;
  logic [9:0]   req_wb_addr;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rdata;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  main_memory_wb_ctrl #(.LATENCY(Lat)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wb_addr (req_wb_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, " rd_count"}, {112'd0, rd_count}, 128'(exp_rd));
    check({tag, " wr_count"}, {112'd0, wr_count}, 128'(exp_wr));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the consume edge.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [9:0] addr,
                        input logic [9:0] wb, input logic [127:0] wdata, input int exp_lat,
                        input logic [127:0] exp_rdata, input int hold);
    int n;
    logic [127:0] held;
    check({tag, " ready"}, {127'd0, req_ready}, 128'd1);
    req_valid   = 1'b1;
    req_op      = op;
    req_addr    = addr;
    req_wb_addr = wb;
    req_wdata   = wdata;
    @(posedge clock);
    #1;
    req_valid   = 1'b0;
    req_op      = 2'b01;
    req_addr    = 10'h3F0;
    req_wb_addr = 10'h3F0;
    req_wdata   = {4{32'hDEAD_BEEF}};
    @(negedge clock);
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(exp_lat));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    if (hold > 0) begin
      held = resp_rdata;
      for (int i = 0; i < hold; i++) begin
        req_valid = 1'b1;
        @(negedge clock);
        check({tag, " hold valid"}, {127'd0, resp_valid}, 128'd1);
        check({tag, " hold rdata"}, resp_rdata, held);
        check({tag, " hold ready"}, {127'd0, req_ready}, 128'd0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    check({tag, " consumed"}, {127'd0, resp_valid}, 128'd0);
  endtask

  initial begin
    int seen;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = '0;
    req_wb_addr = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst req_ready", {127'd0, req_ready}, 128'd1);
    check("rst resp_valid", {127'd0, resp_valid}, 128'd0);
    check("rst resp_rdata", resp_rdata, 128'd0);
    check_counts("rst");

    do_req("rd040", 2'b00, 10'h040, 10'h000, '0, Lat,
           {32'h40, 32'h44, 32'h48, 32'h4C}, 0);
    exp_rd = 1;
    check_counts("rd040");

    do_req("wr080", 2'b01, 10'h080, 10'h000, {32'hA, 32'hB, 32'hC, 32'hD}, Lat, 128'd0, 0);
    exp_wr = 1;
    check_counts("wr080");

    do_req("rd08C", 2'b00, 10'h08C, 10'h000, '0, Lat, {32'hA, 32'hB, 32'hC, 32'hD}, 0);
    exp_rd = 2;
    check_counts("rd08C");

    do_req("wbf100", 2'b10, 10'h200, 10'h100, {4{32'hFFFF_FFFF}}, 2 * Lat,
           {32'h200, 32'h204, 32'h208, 32'h20C}, 0);
    exp_rd = 3;
    exp_wr = 2;
    check_counts("wbf100");

    do_req("rd100", 2'b00, 10'h100, 10'h000, '0, Lat, {4{32'hFFFF_FFFF}}, 0);
    exp_rd = 4;

    do_req("hazard300", 2'b10, 10'h300, 10'h300, {32'd1, 32'd2, 32'd3, 32'd4}, 2 * Lat,
           {32'd1, 32'd2, 32'd3, 32'd4}, 0);
    exp_rd = 5;
    exp_wr = 3;
    check_counts("hazard300");

    do_req("op11", 2'b11, 10'h3F7, 10'h000, '0, Lat,
           {32'h3F0, 32'h3F4, 32'h3F8, 32'h3FC}, 0);
    exp_rd = 6;

    do_req("stall", 2'b00, 10'h010, 10'h000, '0, Lat,
           {32'h10, 32'h14, 32'h18, 32'h1C}, 5);
    exp_rd = 7;
    check_counts("stall");
    check("stall idle", {127'd0, req_ready}, 128'd1);

    // Abort a write to 0x040 two edges into WR_WAIT.
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 10'h040;
    req_wdata = {4{32'h5555_AAAA}};
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    check("abort req_ready", {127'd0, req_ready}, 128'd1);
    check("abort resp_valid", {127'd0, resp_valid}, 128'd0);
    check("abort resp_rdata", resp_rdata, 128'd0);
    check_counts("abort");
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) seen++;
    end
    check("abort no resp", 128'(seen), 128'd0);
    check_counts("abort later");

    do_req("rd040 post", 2'b00, 10'h040, 10'h000, '0, Lat,
           {32'h40, 32'h44, 32'h48, 32'h4C}, 0);
    exp_rd = 1;
    check_counts("rd040 post");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/main_memory_wb_ctrl.md
Name: main_memory_wb_ctrl

Overview:
Clocked main-memory responder serving block requests from the 2-way write-back cache: block reads (fill), block writes (write-back), and a combined write-back-then-fill operation.
- Holds 1 KiB as 64 blocks × 4 words × 32 bits, byte-addressed with 10-bit addresses.
- Adds a programmable access latency and a valid/ready request/response handshake, so the cache controller stalls on misses.
- Sits directly below the cache; it is the memory-side end of the cache/memory block interface.

Parameters:
- LATENCY, 4, cycles per memory access phase; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE.
- req_op  in  2  operation: 00 read block, 01 write block, 10 write-back+fill, 11 reserved (treated as read).
- req_addr  in  10  byte address of the block to read, or to write for op 01; bits [3:0] ignored.
- req_wb_addr  in  10  victim block byte address for op 10; bits [3:0] ignored.
- req_wdata  in  128  block write data; [127:96]=word 0 … [31:0]=word 3.
- resp_valid  out  1  response pending.
- resp_ready  in  1  requester consumes the response.
- resp_rdata  out  128  read block (same word order); 0 for op 01.
- rd_count  out  16  completed block reads; wraps at 16'hFFFF→0.
- wr_count  out  16  completed block writes; wraps.

Behaviour:
- Storage:
  - Block index = addr[9:4]; word w of a block occupies bits [127-32w -: 32].
  - Initial contents: each word holds its own byte address, zero-extended (word at 0x044 = 32'h44).
  - reset does not alter storage.
- Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, rd_count=0, wr_count=0, latency counter=0.
- Reset mid-operation:
  - Aborts the operation; the response is never issued.
  - A write whose commit edge has not occurred is not performed.
- Acceptance:
  - A request is accepted on an edge where req_valid && req_ready.
  - req_op, req_addr, req_wb_addr and req_wdata are latched on that edge; later input changes have no effect.
- States:
  - IDLE: req_ready=1. On accept:
    - op 01 or 10 → WR_WAIT.
    - op 00 or 11 → RD_WAIT.
    - The counter loads LATENCY-1.
  - WR_WAIT: counter decrements each edge. On the edge with counter==0:
    - Commit the latched wdata to block wb_addr (op 10) or addr (op 01); wr_count+1.
    - op 01 → RESP with resp_rdata=0.
    - op 10 → RD_WAIT with counter reloaded to LATENCY-1.
  - RD_WAIT: counter decrements. On the edge with counter==0:
    - resp_rdata ← block at latched addr; rd_count+1.
    - → RESP.
  - RESP:
    - resp_valid=1; resp_rdata held stable.
    - On an edge with resp_ready=1 → IDLE, with resp_valid=0 after that edge.
    - req_ready=0 throughout RESP.
- Latency, with accept edge T:
  - op 00/01: resp_valid first high after edge T+LATENCY.
  - op 10: resp_valid first high after edge T+2·LATENCY.
  - Back-to-back: a new request can be accepted on the edge after the response is consumed (one IDLE cycle minimum).
- Hazard: op 10 with wb_addr and addr in the same block returns the just-written data (write commits before the read phase).
- req_ready/resp_valid are registered state decodes and never depend combinationally on req_valid or resp_ready.
- Counter wrap: rd_count or wr_count at 16'hFFFF increments to 0 with no flag.

Test Plan:
- LATENCY=4, reset, then read req_addr=10'h040 at edge T → resp_valid high after T+4; resp_rdata={32'h40,32'h44,32'h48,32'h4C}; rd_count=1.
- Write req_addr=10'h080, wdata={32'hA,32'hB,32'hC,32'hD} → ack after 4 cycles with rdata=0 and wr_count=1. A following read of 10'h08C returns {A,B,C,D}.
- op 10 with wb_addr=10'h100, wdata=all 32'hFFFFFFFF, addr=10'h200 → resp after 8 cycles = {32'h200,32'h204,32'h208,32'h20C}. A later read of 0x100 returns all F's.
- op 10 with wb_addr=addr=10'h300, wdata={1,2,3,4} → resp {1,2,3,4}.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stable, req_ready=0, and a req_valid pulse is ignored. Then resp_ready=1 → IDLE next edge.
- Assert reset 2 cycles into WR_WAIT of a write to 0x040 → outputs return to reset values, no response is issued, and a later read of 0x040 returns the original {32'h40,32'h44,32'h48,32'h4C}.
